// File: rtl/pr_arb.sv
// rtl/pr_arb.sv - CPU / front-panel arbiter and access sequencer for the P-R register port
module pr_arb #(
    parameter int STROB_LEN = 2,
    parameter int FP_STARVE = 8
) (
    input  logic        clk_sys,
    input  logic        _reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [2:0]  cpu_addr,
    input  logic [15:0] cpu_data,
    output logic        cpu_ack,
    input  logic        fp_req,
    input  logic        fp_wr,
    input  logic [2:0]  fp_addr,
    input  logic [15:0] fp_data,
    output logic        fp_ack,
    input  logic        fp_en,
    output logic [15:0] rdata,
    input  logic [15:0] l,
    output logic [15:0] w,
    output logic        ra,
    output logic        rb,
    output logic        rc,
    output logic        w_r,
    output logic        as2,
    output logic        strob1,
    output logic        blr,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_SAMPLE = 3'd4;
    localparam logic [2:0] ST_ACK    = 3'd5;

    localparam logic [3:0] STROB_LEN_L = 4'(STROB_LEN);
    localparam logic [7:0] FP_STARVE_L = 8'(FP_STARVE);

    logic [2:0]  state;
    logic        rst_done;
    logic        owner_fp;
    logic        lat_wr;
    logic [2:0]  lat_addr;
    logic [15:0] lat_data;
    logic [3:0]  strob_cnt;
    logic [7:0]  starve_cnt;
    logic [15:0] rdata_q;

    logic        fp_elig;
    logic        fp_win;
    logic        cpu_win;
    logic        xfer_phase;

    // Arbitration is held off for one edge after reset release so recovery is clean.
    assign fp_elig = fp_req & fp_en;
    assign fp_win  = rst_done & fp_elig & (~cpu_req | (starve_cnt >= FP_STARVE_L));
    assign cpu_win = rst_done & cpu_req & ~fp_win;

    always_ff @(posedge clk_sys or negedge _reset) begin
        if (!_reset) begin
            state      <= ST_IDLE;
            rst_done   <= 1'b0;
            owner_fp   <= 1'b0;
            lat_wr     <= 1'b0;
            lat_addr   <= 3'd0;
            lat_data   <= 16'h0000;
            strob_cnt  <= 4'd0;
            starve_cnt <= 8'd0;
            rdata_q    <= 16'h0000;
        end else begin
            rst_done <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (fp_win) begin
                        state      <= ST_SETUP;
                        owner_fp   <= 1'b1;
                        lat_wr     <= fp_wr;
                        lat_addr   <= fp_addr;
                        lat_data   <= fp_data;
                        starve_cnt <= 8'd0;
                    end else if (cpu_win) begin
                        state    <= ST_SETUP;
                        owner_fp <= 1'b0;
                        lat_wr   <= cpu_wr;
                        lat_addr <= cpu_addr;
                        lat_data <= cpu_data;
                        if (!fp_elig) begin
                            starve_cnt <= 8'd0;
                        end else if (starve_cnt != 8'hFF) begin
                            starve_cnt <= starve_cnt + 8'd1;
                        end
                    end else begin
                        starve_cnt <= 8'd0;
                    end
                end
                ST_SETUP: begin
                    if (lat_wr) begin
                        state     <= ST_STROBE;
                        strob_cnt <= STROB_LEN_L;
                    end else begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_STROBE: begin
                    strob_cnt <= strob_cnt - 4'd1;
                    if (strob_cnt <= 4'd1) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    state <= ST_ACK;
                end
                ST_SAMPLE: begin
                    rdata_q <= l;
                    state   <= ST_ACK;
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Address, data and w_r are presented from SETUP until the ack cycle, then released.
    assign xfer_phase = (state == ST_SETUP) | (state == ST_STROBE) |
                        (state == ST_HOLD)  | (state == ST_SAMPLE);

    assign ra      = xfer_phase & lat_addr[0];
    assign rb      = xfer_phase & lat_addr[1];
    assign rc      = xfer_phase & lat_addr[2];
    assign w_r     = xfer_phase & lat_wr;
    assign w       = (xfer_phase & lat_wr) ? lat_data : 16'h0000;
    assign strob1  = (state == ST_STROBE);
    assign busy    = (state != ST_IDLE);
    assign blr     = busy & owner_fp;
    assign cpu_ack = (state == ST_ACK) & ~owner_fp;
    assign fp_ack  = (state == ST_ACK) & owner_fp;
    assign as2     = 1'b0;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_pr_arb.sv
// tb/tb_pr_arb.sv - self-checking bench for pr_arb with a transaction-level reference model
module tb_pr_arb;

    localparam int STROB_LEN = 2;
    localparam int FP_STARVE = 8;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic        cpu_req = 1'b0, cpu_wr = 1'b0, fp_req = 1'b0, fp_wr = 1'b0, fp_en = 1'b0;
    logic [2:0]  cpu_addr = 3'd0, fp_addr = 3'd0;
    logic [15:0] cpu_data = 16'h0, fp_data = 16'h0, l = 16'h0;
    logic        cpu_ack, fp_ack, ra, rb, rc, w_r, as2, strob1, blr, busy;
    logic [15:0] rdata, w;

    int checks = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    pr_arb #(.STROB_LEN(STROB_LEN), .FP_STARVE(FP_STARVE)) dut (
        .clk_sys(clk_sys), ._reset(rst_n),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
        .fp_req(fp_req), .fp_wr(fp_wr), .fp_addr(fp_addr), .fp_data(fp_data), .fp_ack(fp_ack),
        .fp_en(fp_en), .rdata(rdata), .l(l), .w(w), .ra(ra), .rb(rb), .rc(rc),
        .w_r(w_r), .as2(as2), .strob1(strob1), .blr(blr), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a transaction is a run of cycles indexed by position from SETUP.
    bit          m_ready, m_busy, m_fp, m_wr;
    int          m_pos, m_len, m_starve;
    logic [2:0]  m_addr;
    logic [15:0] m_data, m_rdata;
    bit          m_elig;

    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 0; m_busy <= 0; m_fp <= 0; m_wr <= 0; m_pos <= 0; m_len <= 0;
            m_starve <= 0; m_addr <= 0; m_data <= 0; m_rdata <= 0;
        end else if (!m_busy) begin
            m_ready <= 1;
            m_elig = fp_req && fp_en;
            if (m_ready && m_elig && (!cpu_req || m_starve >= FP_STARVE)) begin
                m_busy <= 1; m_pos <= 0; m_fp <= 1; m_wr <= fp_wr; m_addr <= fp_addr; m_data <= fp_data;
                m_len <= fp_wr ? STROB_LEN + 3 : 3;
                m_starve <= 0;
            end else if (m_ready && cpu_req) begin
                m_busy <= 1; m_pos <= 0; m_fp <= 0; m_wr <= cpu_wr; m_addr <= cpu_addr; m_data <= cpu_data;
                m_len <= cpu_wr ? STROB_LEN + 3 : 3;
                m_starve <= m_elig ? ((m_starve < 255) ? m_starve + 1 : 255) : 0;
            end else begin
                m_starve <= 0;
            end
        end else begin
            if (!m_wr && m_pos == 1) m_rdata <= l;
            if (m_pos == m_len - 1) m_busy <= 0;
            else m_pos <= m_pos + 1;
        end
    end

    logic [25:0] exp_vec, act_vec;
    bit e_ack, e_phase;

    always @(negedge clk_sys) begin
        e_ack   = m_busy && (m_pos == m_len - 1);
        e_phase = m_busy && !e_ack;
        exp_vec = {m_busy, m_busy && m_fp, m_busy && m_wr && m_pos >= 1 && m_pos <= STROB_LEN,
                   e_phase && m_wr, e_phase && m_addr[2], e_phase && m_addr[1], e_phase && m_addr[0],
                   1'b0, e_ack && !m_fp, e_ack && m_fp, (e_phase && m_wr) ? m_data : 16'h0};
        act_vec = {busy, blr, strob1, w_r, rc, rb, ra, as2, cpu_ack, fp_ack, w};
        check("cycle_outputs", 64'(act_vec), 64'(exp_vec));
        check("cycle_rdata", 64'(rdata), 64'(m_rdata));
    end

    int strobe_seen = 0, cpu_ack_seen = 0, fp_ack_seen = 0;
    always @(negedge clk_sys) begin
        if (strob1) strobe_seen++;
        if (cpu_ack) cpu_ack_seen++;
        if (fp_ack) fp_ack_seen++;
    end

    task automatic wait_ack(output int edges, output logic got_fp);
        bit done;
        done = 0; edges = 0; got_fp = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk_sys); #1;
            edges++;
            if (cpu_ack || fp_ack) begin
                got_fp = fp_ack;
                done = 1;
            end
        end
        if (!done) check("ack_timeout", 64'(1), 64'(0));
    endtask

    int   edges, s0, f0, a0, busy_cnt, cpu_run, first_fp, second_fp;
    logic got_fp;

    initial begin
        // Reset held with a pending CPU write of R3
        cpu_req = 1; cpu_wr = 1; cpu_addr = 3'd3; cpu_data = 16'hA5C3;
        repeat (3) @(posedge clk_sys);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_strob1", 64'(strob1), 64'(0));
        rst_n = 1;
        @(posedge clk_sys); #1;
        check("recover_edge1_idle", 64'(busy), 64'(0));
        @(posedge clk_sys); #1;
        check("cpu_wr_setup_busy", 64'(busy), 64'(1));
        check("cpu_wr_setup_addr", 64'({rc, rb, ra}), 64'(3'b011));
        check("cpu_wr_setup_w", 64'(w), 64'(16'hA5C3));
        check("cpu_wr_setup_w_r", 64'(w_r), 64'(1));
        s0 = strobe_seen; f0 = fp_ack_seen;
        wait_ack(edges, got_fp);
        check("cpu_wr_latency", 64'(edges), 64'(4));
        check("cpu_wr_owner", 64'(got_fp), 64'(0));
        check("cpu_wr_strobe_len", 64'(strobe_seen - s0), 64'(2));
        check("cpu_wr_no_fp_ack", 64'(fp_ack_seen - f0), 64'(0));
        cpu_req = 0;

        // Panel read of R0
        @(posedge clk_sys); #1;
        fp_req = 1; fp_wr = 0; fp_addr = 3'd0; fp_en = 1; l = 16'h1234;
        s0 = strobe_seen;
        @(posedge clk_sys); #1;
        check("fp_rd_setup_busy", 64'(busy), 64'(1));
        check("fp_rd_setup_blr", 64'(blr), 64'(1));
        check("fp_rd_setup_w_r", 64'(w_r), 64'(0));
        wait_ack(edges, got_fp);
        check("fp_rd_latency", 64'(edges), 64'(2));
        check("fp_rd_owner", 64'(got_fp), 64'(1));
        check("fp_rd_rdata_ack", 64'(rdata), 64'(16'h1234));
        check("fp_rd_blr_ack", 64'(blr), 64'(1));
        fp_req = 0; l = 16'hFFFF;
        repeat (3) @(posedge clk_sys);
        #1;
        check("fp_rd_rdata_held", 64'(rdata), 64'(16'h1234));
        check("fp_rd_blr_idle", 64'(blr), 64'(0));
        check("fp_rd_no_strobe", 64'(strobe_seen - s0), 64'(0));

        // Contention: both requesters held continuously
        cpu_req = 1; cpu_wr = 1; cpu_addr = 3'd5; cpu_data = 16'h1111;
        fp_req = 1; fp_wr = 1; fp_addr = 3'd7; fp_data = 16'h0F0F;
        cpu_run = 0; first_fp = -1; second_fp = -1;
        for (int k = 0; k < 18; k++) begin
            wait_ack(edges, got_fp);
            if (got_fp) begin
                if (first_fp < 0) first_fp = k;
                else if (second_fp < 0) second_fp = k;
            end else begin
                cpu_run++;
                cpu_data = ~cpu_data;
            end
        end
        cpu_req = 0; fp_req = 0;
        check("starve_first_fp_index", 64'(first_fp), 64'(8));
        check("starve_second_fp_index", 64'(second_fp), 64'(17));
        check("starve_cpu_acks", 64'(cpu_run), 64'(16));

        // Panel request gated by fp_en
        @(posedge clk_sys); #1;
        fp_en = 0; fp_req = 1; fp_wr = 0; fp_addr = 3'd2;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_sys); #1;
            if (busy) busy_cnt++;
        end
        check("fp_en_off_no_grant", 64'(busy_cnt), 64'(0));
        fp_en = 1;
        @(posedge clk_sys); #1;
        check("fp_en_on_setup", 64'({busy, blr}), 64'(2'b11));
        wait_ack(edges, got_fp);
        check("fp_en_on_owner", 64'(got_fp), 64'(1));
        fp_req = 0;

        // Async reset in the middle of a strobe
        @(posedge clk_sys); #1;
        cpu_req = 1; cpu_wr = 1; cpu_addr = 3'd6; cpu_data = 16'h5A5A;
        @(posedge clk_sys); #1;
        check("rst_mid_setup", 64'(busy), 64'(1));
        @(posedge clk_sys); #1;
        check("rst_mid_strobe_on", 64'(strob1), 64'(1));
        a0 = cpu_ack_seen;
        #2 rst_n = 0;
        #1;
        check("rst_mid_strobe_off", 64'({strob1, busy, cpu_ack}), 64'(0));
        @(posedge clk_sys); #1;
        rst_n = 1;
        check("rst_mid_no_ack", 64'(cpu_ack_seen - a0), 64'(0));
        s0 = strobe_seen;
        @(posedge clk_sys); #1;
        check("rst_mid_recover_idle", 64'(busy), 64'(0));
        @(posedge clk_sys); #1;
        check("rst_mid_reserve_w", 64'({busy, w}), 64'({1'b1, 16'h5A5A}));
        wait_ack(edges, got_fp);
        check("rst_mid_reserve_latency", 64'(edges), 64'(4));
        check("rst_mid_reserve_strobe", 64'(strobe_seen - s0), 64'(2));
        cpu_req = 0;
        repeat (3) @(posedge clk_sys);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
